bus_init_sequencer: RTL and testbench

- Central controller that brings up the CAN buses of mopshub_top one at a time after reset or on request.
- For each bus index 0..n_buses it:
  - asserts a power-enable pulse,
  - waits a settle time,
  - optionally triggers oscillator trimming of the MOPS on that bus,
  - waits for trim completion or a timeout.
- Drives the power_bus_en/power_bus_cnt/start_init/end_init handshake consumed by the power, trim and data-generator logic.
- Records a per-bus pass bitmap.

---
 rtl/bus_init_sequencer_if.sv | 29 ++
 rtl/bus_init_sequencer.sv | 149 ++++++++++++++
 tb/tb_bus_init_sequencer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/bus_init_sequencer_if.sv
// Control and status bundle between the bus init sequencer and
// the power, trim and data-generator logic.
interface bus_init_sequencer_if;
   logic        start;
   logic [4:0]  n_buses;
   logic        trim_en;
   logic        trim_done;
   logic        abort;
   logic        power_bus_en;
   logic [4:0]  power_bus_cnt;
   logic        start_trim;
   logic        start_init;
   logic        end_init;
   logic        busy;
   logic [31:0] bus_ok;
   logic        err_timeout;

   modport master (
      input  start, n_buses, trim_en, trim_done, abort,
      output power_bus_en, power_bus_cnt, start_trim,
      output start_init, end_init, busy, bus_ok, err_timeout
   );

   modport slave (
      output start, n_buses, trim_en, trim_done, abort,
      input  power_bus_en, power_bus_cnt, start_trim,
      input  start_init, end_init, busy, bus_ok, err_timeout
   );
endinterface

// File: rtl/bus_init_sequencer.sv
// Brings up CAN buses 0..n_buses one at a time: power pulse, settle,
// optional oscillator trim with timeout; records per-bus pass bitmap.
module bus_init_sequencer #(
   parameter int SETTLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int CNT_W          = 13
) (
   input logic clk,
   input logic rst,
   bus_init_sequencer_if.master bus
);
   typedef enum logic [2:0] {
      IDLE, POWER, SETTLE, TRIM, WAIT_DONE, NEXT, DONE
   } state_t;

   localparam logic [CNT_W-1:0] SETTLE_LAST  =
      CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST =
      CNT_W'(TIMEOUT_CYCLES - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [4:0]        last_q, last_d;
   logic [4:0]        idx_q, idx_d;
   logic              te_q, te_d;
   logic [31:0]       ok_q, ok_d;
   logic              err_q, err_d;
   logic              pwr_q, pwr_d;
   logic              trim_q, trim_d;
   logic              sinit_q, sinit_d;
   logic              einit_q, einit_d;
   logic              busy_q, busy_d;
   logic              live;

   assign live = (state_q != IDLE) && (state_q != DONE);

   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      last_d  = last_q;
      idx_d   = idx_q;
      te_d    = te_q;
      ok_d    = ok_q;
      err_d   = err_q;
      pwr_d   = 1'b0;
      trim_d  = 1'b0;
      sinit_d = 1'b0;
      einit_d = 1'b0;
      // abort outranks any completion in the same cycle
      if (live && bus.abort) begin
         state_d = DONE;
         einit_d = 1'b1;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.start) begin
                  state_d = POWER;
                  last_d  = bus.n_buses;
                  te_d    = bus.trim_en;
                  idx_d   = '0;
                  ok_d    = '0;
                  err_d   = 1'b0;
                  pwr_d   = 1'b1;
                  sinit_d = 1'b1;
               end
            end
            POWER: state_d = SETTLE;
            SETTLE: begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == SETTLE_LAST) begin
                  cnt_d = '0;
                  if (te_q) begin
                     state_d = TRIM;
                     trim_d  = 1'b1;
                  end else begin
                     state_d       = NEXT;
                     ok_d[idx_q]   = 1'b1;
                  end
               end
            end
            TRIM: state_d = WAIT_DONE;
            WAIT_DONE: begin
               cnt_d = cnt_q + CNT_W'(1);
               if (bus.trim_done) begin
                  state_d     = NEXT;
                  ok_d[idx_q] = 1'b1;
                  cnt_d       = '0;
               end else if (cnt_q == TIMEOUT_LAST) begin
                  state_d = NEXT;
                  err_d   = 1'b1;
                  cnt_d   = '0;
               end
            end
            NEXT: begin
               if (idx_q == last_q) begin
                  state_d = DONE;
                  einit_d = 1'b1;
               end else begin
                  state_d = POWER;
                  idx_d   = idx_q + 5'd1;
                  pwr_d   = 1'b1;
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         last_q  <= '0;
         idx_q   <= '0;
         te_q    <= 1'b0;
         ok_q    <= '0;
         err_q   <= 1'b0;
         pwr_q   <= 1'b0;
         trim_q  <= 1'b0;
         sinit_q <= 1'b0;
         einit_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         idx_q   <= idx_d;
         te_q    <= te_d;
         ok_q    <= ok_d;
         err_q   <= err_d;
         pwr_q   <= pwr_d;
         trim_q  <= trim_d;
         sinit_q <= sinit_d;
         einit_q <= einit_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.power_bus_en  = pwr_q;
   assign bus.power_bus_cnt = idx_q;
   assign bus.start_trim    = trim_q;
   assign bus.start_init    = sinit_q;
   assign bus.end_init      = einit_q;
   assign bus.busy          = busy_q;
   assign bus.bus_ok        = ok_q;
   assign bus.err_timeout   = err_q;
endmodule

// File: tb/tb_bus_init_sequencer.sv
// Bench for bus_init_sequencer: directed and random runs compared
// against a cycle-arithmetic model of the bring-up timeline.
module tb_bus_init_sequencer;
   localparam int ST = 16;
   localparam int TO = 8;

   logic clk;
   logic rst;
   logic trim_resp;
   logic trim_glitch;
   int   cyc = 0;
   int   errs = 0;
   int   checks = 0;
   int   dly [32];

   bus_init_sequencer_if bif();

   assign bif.trim_done = trim_resp | trim_glitch;

   bus_init_sequencer #(
      .SETTLE_CYCLES (ST),
      .TIMEOUT_CYCLES(TO),
      .CNT_W         (13)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bif.master)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // trimming logic stand-in: answers dly[bus] cycles after start_trim
   initial begin
      int d;
      trim_resp = 1'b0;
      forever begin
         @(negedge clk);
         if (bif.start_trim === 1'b1 && dly[bif.power_bus_cnt] != 0) begin
            d = dly[bif.power_bus_cnt];
            repeat (d) @(negedge clk);
            trim_resp = 1'b1;
            @(negedge clk);
            trim_resp = 1'b0;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] outs();
      return 64'({bif.power_bus_en, bif.power_bus_cnt, bif.start_trim,
                  bif.start_init, bif.end_init, bif.busy,
                  bif.bus_ok, bif.err_timeout});
   endfunction

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ab/sb/gl/rs: cycle (1 = first POWER cycle) in which abort,
   // a stray start, a stray trim_done or rst is applied; 0 = none
   task automatic run(input int n, input bit te, input int ab,
                      input int sb, input int gl, input int rs);
      int p [33];
      int tcy [32];
      int pc[$], pix[$], tc[$], ec[$], sc[$];
      int n_pw, n_tr, stop, endc, lim, s0, rel, w;
      logic [31:0] okm;
      bit er;
      p[0] = 1; okm = '0; er = 0; n_pw = 0; n_tr = 0;
      stop = ab > 0 ? ab : (rs > 0 ? rs : 1 << 30);
      for (int i = 0; i <= n; i++) begin
         bit ok;
         if (te) begin
            ok = dly[i] != 0 && dly[i] <= TO;
            w = ok ? dly[i] : TO;
            tcy[i] = p[i] + ST + 1;
            p[i+1] = p[i] + ST + 3 + w;
         end else begin
            ok = 1;
            tcy[i] = 0;
            p[i+1] = p[i] + ST + 2;
         end
         if (p[i] <= stop) n_pw++;
         if (te && tcy[i] <= stop) n_tr++;
         if (p[i+1] - 1 <= stop) begin
            if (ok) okm[i] = 1'b1;
            else er = 1;
         end
      end
      endc = ab > 0 ? ab + 1 : p[n+1];
      lim = rs > 0 ? rs + 4 : endc;

      @(negedge clk);
      bif.n_buses = 5'(n);
      bif.trim_en = te;
      bif.start = 1'b1;
      s0 = cyc + 1;
      for (int k = 0; k < lim + 5; k++) begin
         @(negedge clk);
         rel = cyc - s0 + 1;
         if (rel == 1) begin
            chk("clr_ok", bif.bus_ok, 0);
            chk("clr_err", bif.err_timeout, 0);
         end
         if (bif.power_bus_en) begin
            pc.push_back(rel);
            pix.push_back(int'(bif.power_bus_cnt));
         end
         if (bif.start_trim) tc.push_back(rel);
         if (bif.start_init) sc.push_back(rel);
         if (bif.end_init) ec.push_back(rel);
         if (rs > 0 && rel == rs + 1) chk("rst_outs", outs(), 0);
         bif.start = (rel == sb);
         bif.abort = (rel == ab);
         trim_glitch = (rel == gl);
         rst = (rel == rs);
         bif.n_buses = 5'($urandom);
         bif.trim_en = 1'($urandom);
         if (rel >= lim) break;
      end
      bif.start = 1'b0;
      bif.abort = 1'b0;
      trim_glitch = 1'b0;
      rst = 1'b0;

      chk("n_pwr", pc.size(), n_pw);
      for (int i = 0; i < pc.size() && i < n_pw; i++) begin
         chk("pwr_cyc", pc[i], p[i]);
         chk("pwr_idx", pix[i], i);
      end
      chk("n_trim", tc.size(), n_tr);
      for (int i = 0; i < tc.size() && i < n_tr; i++)
         chk("trim_cyc", tc[i], tcy[i]);
      chk("n_sinit", sc.size(), 1);
      if (sc.size() > 0) chk("sinit_cyc", sc[0], 1);
      if (rs > 0) begin
         chk("n_einit_rst", ec.size(), 0);
      end else begin
         chk("n_einit", ec.size(), 1);
         if (ec.size() > 0) chk("einit_cyc", ec[0], endc);
         @(negedge clk);
         chk("busy_end", bif.busy, 0);
         chk("einit_off", bif.end_init, 0);
         chk("bus_ok", bif.bus_ok, okm);
         chk("err_to", bif.err_timeout, er);
      end
   endtask

   initial begin
      rst = 1'b1;
      bif.start = 1'b0;
      bif.abort = 1'b0;
      bif.n_buses = '0;
      bif.trim_en = 1'b0;
      trim_glitch = 1'b0;
      for (int i = 0; i < 32; i++) dly[i] = 5;
      repeat (3) @(negedge clk);
      chk("reset_outs", outs(), 0);
      rst = 1'b0;
      idle(2);
      chk("idle_outs", outs(), 0);

      // single bus, power/settle only: end_init in cycle 19
      run(0, 0, 0, 0, 0, 0);
      idle(12);
      // four buses trimmed, trim_done 5 cycles after start_trim
      run(3, 1, 0, 0, 0, 0);
      idle(12);
      // bus 1 never answers and times out
      dly[1] = 0;
      run(2, 1, 0, 0, 0, 0);
      idle(12);
      // trim_done on the timeout cycle counts as success
      dly[0] = TO;
      run(0, 1, 0, 0, 0, 0);
      idle(12);
      // stray trim_done in SETTLE is ignored, timeout still taken
      dly[0] = 0;
      run(0, 1, 0, 0, 5, 0);
      idle(12);
      // abort in SETTLE of bus 10, then a fresh run
      run(31, 0, 1 + 10 * (ST + 2) + 4, 0, 0, 0);
      idle(4);
      run(2, 0, 0, 0, 0, 0);
      idle(12);
      // reset during WAIT_DONE of bus 4
      for (int i = 0; i < 32; i++) dly[i] = 5;
      run(5, 1, 0, 0, 0, 1 + 4 * (ST + 8) + ST + 3);
      idle(12);
      // start while busy is ignored
      run(3, 1, 0, 30, 0, 0);
      idle(12);
      // random runs
      for (int r = 0; r < 8; r++) begin
         int n;
         bit te;
         n = $urandom_range(0, 4);
         te = 1'($urandom_range(0, 1));
         for (int i = 0; i < 32; i++)
            dly[i] = ($urandom_range(0, 3) == 0) ? 0 :
                     $urandom_range(1, TO + 3);
         run(n, te, 0, $urandom_range(2, 18), 0, 0);
         idle(14);
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
